// File: rtl/transmite_medida_pkg.sv
// Shared definitions for the distance transmitter: FSM encoding, ASCII
// constants and default UART timing (50 MHz clock, 115200 baud).
package transmite_medida_pkg;

  localparam int         CLKS_PER_BIT_DEFAULT = 434;
  localparam logic [7:0] ASCII_HASH           = 8'h23;
  localparam logic [3:0] ASCII_DIGIT_HI       = 4'h3;
  localparam logic [1:0] LAST_IDX             = 2'd3;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    CARREGA     = 3'd1,
    INICIA_CHAR = 3'd2,
    ESPERA_CHAR = 3'd3,
    PROXIMO     = 3'd4,
    FIM         = 3'd5
  } estado_t;

  // Digits are sent as {3,d} with no BCD check, so A-F become ':'..'?'.
  function automatic logic [7:0] ascii_digit(input logic [3:0] d);
    return {ASCII_DIGIT_HI, d};
  endfunction

endpackage

// File: rtl/transmite_medida_if.sv
// Request/status bundle between a requester and transmite_medida, plus the
// FSM state brought out for observation.
interface transmite_medida_if;
  import transmite_medida_pkg::*;

  // transmitir is a request level sampled only while idle; ocupado is high from
  // the cycle after acceptance until pronto, which pulses for one cycle.
  logic        transmitir;
  logic [11:0] distancia;
  logic        saida_serial;
  logic        ocupado;
  logic        pronto;
  estado_t     estado;

  modport master (
    output transmitir, distancia,
    input  saida_serial, ocupado, pronto, estado
  );

  modport slave (
    input  transmitir, distancia,
    output saida_serial, ocupado, pronto, estado
  );

endinterface

// File: rtl/tx_serial_8N1.sv
// 8N1 serializer: a 10-bit frame shifted out LSB first, each bit held
// CLKS_PER_BIT clocks, with the line driven from a registered output.
module tx_serial_8N1 #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       partida,
  input  logic [7:0] dados,
  output logic       saida_serial,
  output logic       pronto
);

  localparam int          CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  logic          busy_q, busy_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [9:0]    shift_q, shift_d;
  logic          saida_q, saida_d;
  logic          fim_bit;

  assign fim_bit      = (clk_cnt_q == CNT_MAX);
  // Asserted during the last clock of the stop bit as seen by the shifter.
  assign pronto       = busy_q && fim_bit && (bit_cnt_q == 4'd9);
  assign saida_serial = saida_q;

  always_comb begin
    busy_d    = busy_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    saida_d   = shift_q[0];
    if (!busy_q) begin
      if (partida) begin
        shift_d   = {1'b1, dados, 1'b0};
        busy_d    = 1'b1;
        clk_cnt_d = '0;
        bit_cnt_d = '0;
      end
    end else if (fim_bit) begin
      clk_cnt_d = '0;
      if (bit_cnt_q == 4'd9) begin
        busy_d = 1'b0;
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
        shift_d   = {1'b1, shift_q[9:1]};
      end
    end else begin
      clk_cnt_d = clk_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q    <= 1'b0;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '1;
      saida_q   <= 1'b1;
    end else begin
      busy_q    <= busy_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      saida_q   <= saida_d;
    end
  end

endmodule

// File: rtl/transmite_medida.sv
// Sends a captured 3-digit BCD distance as "DDD#" over an 8N1 UART line,
// sequencing four characters through tx_serial_8N1.
module transmite_medida
  import transmite_medida_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  transmite_medida_if.slave  bus
);

  estado_t     state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [11:0] snap_q, snap_d;
  logic        ocupado_q, ocupado_d;
  logic        pronto_q, pronto_d;
  logic        partida;
  logic        tx_pronto;
  logic        tx_saida;
  logic [7:0]  char_atual;

  always_comb begin
    char_atual = ASCII_HASH;
    case (idx_q)
      2'd0:    char_atual = ascii_digit(snap_q[11:8]);
      2'd1:    char_atual = ascii_digit(snap_q[7:4]);
      2'd2:    char_atual = ascii_digit(snap_q[3:0]);
      default: char_atual = ASCII_HASH;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    snap_d    = snap_q;
    ocupado_d = ocupado_q;
    pronto_d  = 1'b0;
    partida   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.transmitir) begin
          state_d   = CARREGA;
          ocupado_d = 1'b1;
        end
      end
      CARREGA: begin
        snap_d  = bus.distancia;
        idx_d   = 2'd0;
        state_d = INICIA_CHAR;
      end
      INICIA_CHAR: begin
        partida = 1'b1;
        state_d = ESPERA_CHAR;
      end
      ESPERA_CHAR: begin
        if (tx_pronto) state_d = PROXIMO;
      end
      PROXIMO: begin
        if (idx_q != LAST_IDX) begin
          idx_d   = idx_q + 2'd1;
          state_d = INICIA_CHAR;
        end else begin
          state_d = FIM;
        end
      end
      FIM: begin
        pronto_d  = 1'b1;
        ocupado_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= 2'd0;
      snap_q    <= 12'h000;
      ocupado_q <= 1'b0;
      pronto_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      ocupado_q <= ocupado_d;
      pronto_q  <= pronto_d;
    end
  end

  tx_serial_8N1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clock        (clock),
    .reset        (reset),
    .partida      (partida),
    .dados        (char_atual),
    .saida_serial (tx_saida),
    .pronto       (tx_pronto)
  );

  assign bus.saida_serial = tx_saida;
  assign bus.ocupado      = ocupado_q;
  assign bus.pronto       = pronto_q;
  assign bus.estado       = state_q;

endmodule

// File: tb/tb_transmite_medida.sv
// Directed bench for transmite_medida at 4 clocks per bit, checking the line
// waveform, ocupado/pronto timing and decoded characters of each message.
module tb_transmite_medida;
  import transmite_medida_pkg::*;

  localparam int C       = 4;
  localparam int MSG_LEN = 40 * C + 10;
  localparam int CHAR_T  = 10 * C + 2;

  logic clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  logic [7:0] msg [4];

  transmite_medida_if bus ();

  transmite_medida #(.CLKS_PER_BIT(C)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_check(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      chk($sformatf("%s line %0d", tag, i), bus.saida_serial, 1'b1);
      chk($sformatf("%s ocupado %0d", tag, i), bus.ocupado, 1'b0);
      chk($sformatf("%s pronto %0d", tag, i), bus.pronto, 1'b0);
    end
  endtask

  // Raise transmitir for exactly one sampling edge; returns on the negedge after it.
  task automatic req_pulse();
    @(negedge clock);
    bus.transmitir = 1'b1;
    @(negedge clock);
    bus.transmitir = 1'b0;
  endtask

  // Called on the negedge right after the sampling edge (k=0). Expected line:
  // character j starts at k = 3 + j*(10C+2), bits held C clocks, high otherwise.
  task automatic run_msg(input logic [7:0] exp_b [4], input int stop_k,
                         input int chg_k, input logic [11:0] chg_val, input int pulse_k);
    logic [9:0] frame [4];
    logic [7:0] got [4];
    logic       exp_line;
    int         s;
    int         rel;
    for (int j = 0; j < 4; j++) begin
      frame[j] = {1'b1, exp_b[j], 1'b0};
      got[j]   = 8'h00;
    end
    for (int k = 0; k <= stop_k; k++) begin
      if (k > 0) @(negedge clock);
      exp_line = 1'b1;
      for (int j = 0; j < 4; j++) begin
        s = 3 + j * CHAR_T;
        if (k >= s && k < s + 10 * C) begin
          rel      = k - s;
          exp_line = frame[j][rel / C];
          if (rel / C >= 1 && rel / C <= 8 && rel % C == C / 2)
            got[j][rel / C - 1] = bus.saida_serial;
        end
      end
      chk($sformatf("line k=%0d", k), bus.saida_serial, exp_line);
      chk($sformatf("ocupado k=%0d", k), bus.ocupado, (k < MSG_LEN));
      chk($sformatf("pronto k=%0d", k), bus.pronto, (k == MSG_LEN));
      if (k == chg_k) bus.distancia = chg_val;
      if (pulse_k >= 0 && k == pulse_k) bus.transmitir = 1'b1;
      if (pulse_k >= 0 && k == pulse_k + 1) bus.transmitir = 1'b0;
    end
    if (stop_k == MSG_LEN) begin
      for (int j = 0; j < 4; j++)
        chk($sformatf("char %0d", j), got[j], exp_b[j]);
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus.transmitir = 1'b0;
    bus.distancia  = 12'h000;
    repeat (3) @(negedge clock);
    chk("reset line", bus.saida_serial, 1'b1);
    chk("reset ocupado", bus.ocupado, 1'b0);
    chk("reset pronto", bus.pronto, 1'b0);
    chk("reset estado", bus.estado, IDLE);
    reset = 1'b0;
    idle_check(5, "post-reset");

    // Basic message, pronto 170 clocks after sampling.
    bus.distancia = 12'h123;
    msg = '{8'h31, 8'h32, 8'h33, 8'h23};
    req_pulse();
    chk("estado k0", bus.estado, CARREGA);
    run_msg(msg, MSG_LEN, -1, 12'h000, -1);
    idle_check(4, "after 123");

    // All zeros: bit periods and inter-character gaps covered by the waveform.
    bus.distancia = 12'h000;
    msg = '{8'h30, 8'h30, 8'h30, 8'h23};
    req_pulse();
    run_msg(msg, MSG_LEN, -1, 12'h000, -1);
    idle_check(3, "after 000");

    // Input changes during character 1 do not reach the message.
    bus.distancia = 12'h045;
    msg = '{8'h30, 8'h34, 8'h35, 8'h23};
    req_pulse();
    run_msg(msg, MSG_LEN, 60, 12'h999, -1);
    idle_check(3, "after 045");

    // A second request during character 2 is ignored.
    bus.distancia = 12'h258;
    msg = '{8'h32, 8'h35, 8'h38, 8'h23};
    req_pulse();
    run_msg(msg, MSG_LEN, -1, 12'h000, 100);
    idle_check(2 * CHAR_T, "ignored request");

    // Reset in the middle of character 1 aborts the message for good.
    bus.distancia = 12'h456;
    msg = '{8'h34, 8'h35, 8'h36, 8'h23};
    req_pulse();
    run_msg(msg, 60, -1, 12'h000, -1);
    reset = 1'b1;
    @(negedge clock);
    chk("abort line", bus.saida_serial, 1'b1);
    chk("abort ocupado", bus.ocupado, 1'b0);
    chk("abort pronto", bus.pronto, 1'b0);
    chk("abort estado", bus.estado, IDLE);
    reset = 1'b0;
    idle_check(2 * CHAR_T, "no resume");

    bus.distancia = 12'h007;
    msg = '{8'h30, 8'h30, 8'h37, 8'h23};
    req_pulse();
    run_msg(msg, MSG_LEN, -1, 12'h000, -1);
    idle_check(3, "after 007");

    // Held request: two back-to-back messages, non-BCD digits A and F.
    bus.distancia = 12'h0AF;
    msg = '{8'h30, 8'h3A, 8'h3F, 8'h23};
    @(negedge clock);
    bus.transmitir = 1'b1;
    @(negedge clock);
    run_msg(msg, MSG_LEN, -1, 12'h000, -1);
    @(negedge clock);
    chk("held restart estado", bus.estado, CARREGA);
    run_msg(msg, MSG_LEN, -1, 12'h000, -1);
    bus.transmitir = 1'b0;
    idle_check(6, "after held");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/transmite_medida.md
TRANSMITE_MEDIDA -- requirements
Module: transmite_medida

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clocks per serial bit (50 MHz / 115200 baud).
REQ-002 clock  input  1  system clock, 50 MHz; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 transmitir  input  1  start request; sampled only in IDLE.
REQ-005 distancia  input  12  measured distance from the sensor interface, BCD: [11:8] hundreds, [7:4] tens, [3:0] units.
REQ-006 saida_serial  output  1  UART TX line, 8N1, idle high.
REQ-007 ocupado  output  1  high from the cycle after an accepted request until pronto is asserted.
REQ-008 pronto  output  1  one-cycle pulse at the end of a message.

Function
REQ-009 The block shall send a 4-character ASCII message: {4'h3,distancia[11:8]}, {4'h3,distancia[7:4]}, {4'h3,distancia[3:0]}, 8'h23 ('#'), in that order.
REQ-010 The block shall apply no BCD validation; digit values A-F shall be sent as {4'h3,d}.
REQ-011 Each character shall use 1 start bit (0), 8 data bits LSB first and 1 stop bit (1), each held exactly CLKS_PER_BIT clocks.
REQ-012 FSM states: IDLE, CARREGA, INICIA_CHAR, ESPERA_CHAR, PROXIMO, FIM.
REQ-013 IDLE -> CARREGA when transmitir=1 at a clock edge; ocupado shall rise on that edge.
REQ-014 CARREGA shall latch distancia into an internal snapshot register and clear the character index (0..3).
REQ-015 INICIA_CHAR shall issue a one-cycle start to the serial sub-module for character[index], then go to ESPERA_CHAR.
REQ-016 ESPERA_CHAR -> PROXIMO when the sub-module signals stop-bit completion.
REQ-017 PROXIMO shall go to INICIA_CHAR with index+1 if index<3, otherwise to FIM.
REQ-018 FIM shall assert pronto for exactly one cycle, deassert ocupado on the same edge, and return to IDLE.
REQ-019 The start bit of character 0 shall appear on saida_serial exactly 3 clocks after the edge that samples transmitir.
REQ-020 Between consecutive characters saida_serial shall stay high for exactly 2 clocks (PROXIMO, INICIA_CHAR).
REQ-021 transmitir shall be ignored while ocupado=1; a request held high continuously shall start a new message on the cycle after FIM.
REQ-022 Changes on distancia after CARREGA shall not affect the message in progress.
REQ-023 Total time from the sampling edge to pronto shall be 40*CLKS_PER_BIT + 10 clocks.

Reset
REQ-024 When reset=1, the block shall enter IDLE on the next edge regardless of state, with saida_serial=1, ocupado=0, pronto=0, index=0 and the snapshot cleared.
REQ-025 Reset shall have priority over transmitir; a message aborted mid-character shall not be resumed.

Structure
REQ-026 The shared include file shall hold the state encodings, the ASCII constants 8'h23 and 4'h3, and the default CLKS_PER_BIT.
REQ-027 One sub-module, tx_serial_8N1 (parameter CLKS_PER_BIT; ports clock, reset, partida, dados[7:0], saida_serial, pronto), shall implement the bit timing and a 10-bit shift register.
REQ-028 The top level shall contain only the FSM, the snapshot register, the index counter and the character multiplexer.

Verification (bench uses CLKS_PER_BIT=4)
REQ-029 distancia=12'h123, transmitir pulsed once -> bytes 0x31,0x32,0x33,0x23 decoded; pronto at 170 clocks after sampling.
REQ-030 distancia=12'h000 -> 0x30,0x30,0x30,0x23; each bit period exactly 4 clocks; gaps exactly 2 clocks.
REQ-031 distancia changed from 12'h045 to 12'h999 during character 1 -> message reads 0x30,0x34,0x35,0x23.
REQ-032 transmitir pulsed again during character 2 -> ignored; exactly one pronto; ocupado low after it.
REQ-033 reset during character 1 -> saida_serial=1, ocupado=0 next edge; new request with 12'h007 -> 0x30,0x30,0x37,0x23.
REQ-034 transmitir held high for 2 messages with distancia=12'h0AF -> 0x30,0x3A,0x3F,0x23 sent twice, 2 pronto pulses.
